// File: rtl/almacen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : almacen_pkg
// Description : Shared encodings for the multi-gate warehouse controller:
//               per-gate FSM states and gate direction constants.
// Revision    : 1.0 - initial release
// ============================================================================
package almacen_pkg;

  // Per-gate FSM state encoding
  typedef logic [1:0] gate_state_t;

  localparam gate_state_t CLOSED = 2'd0;  // a=0, c=1
  localparam gate_state_t OPEN   = 2'd1;  // a=1, c=0, slot reserved
  localparam gate_state_t PASS   = 2'd2;  // a=1, c=0, item crossing

  // Gate direction, one bit per gate in the DIR mask
  localparam logic ENTRY = 1'b1;  // passage increments occupancy
  localparam logic EXIT  = 1'b0;  // passage decrements occupancy

endpackage : almacen_pkg
`default_nettype wire

// File: rtl/almacen_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : almacen_gate_ctrl_if
// Description : Sensor/actuator bundle between the gate sensors, the gate
//               controller and the door actuators.
// Revision    : 1.0 - initial release
// ============================================================================
interface almacen_gate_ctrl_if #(
  parameter int NCH = 2,
  parameter int CW  = 4
);

  logic [NCH-1:0] s1;     // request sensor per gate
  logic [NCH-1:0] s2;     // passage sensor per gate
  logic [NCH-1:0] a;      // open command per gate
  logic [NCH-1:0] c;      // close command per gate
  logic [CW-1:0]  count;  // current occupancy
  logic           full;
  logic           empty;
  logic [NCH-1:0] alarm;  // tailgating pulse per gate

  // Sensor side: drives sensors, observes actuators and status
  modport master (
    output s1, s2,
    input  a, c, count, full, empty, alarm
  );

  // Controller side
  modport slave (
    input  s1, s2,
    output a, c, count, full, empty, alarm
  );

endinterface : almacen_gate_ctrl_if
`default_nettype wire

// File: rtl/gate_fsm.sv
`default_nettype none
// ============================================================================
// Module      : gate_fsm
// Description : Single gate controller: sensor synchronisers, rising-edge
//               detection, open timeout timer and CLOSED/OPEN/PASS state.
//               The slot grant comes from the arbitration at the top level.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_fsm
  import almacen_pkg::*;
#(
  parameter int TOPEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic s1,         // raw request sensor
  input  logic s2,         // raw passage sensor
  input  logic grant,      // slot granted for this cycle's request
  output logic req_edge,   // s1 rising edge while CLOSED (asks for a slot)
  output logic pass_edge,  // s2 rising edge while OPEN (passage to count)
  output logic is_open,    // slot currently reserved
  output logic a,
  output logic c,
  output logic alarm
);

  localparam int TW = (TOPEN > 2) ? $clog2(TOPEN) : 1;

  // [0],[1] form the synchroniser; [2] is the previous synchronised value
  logic [2:0]    s1_pipe;
  logic [2:0]    s2_pipe;
  gate_state_t   state;
  logic [TW-1:0] timer;

  logic s1_edge;
  logic s2_edge;

  assign s1_edge   = s1_pipe[1] & ~s1_pipe[2];
  assign s2_edge   = s2_pipe[1] & ~s2_pipe[2];
  assign req_edge  = s1_edge & (state == CLOSED);
  assign pass_edge = s2_edge & (state == OPEN);
  assign is_open   = (state == OPEN);

  // Synchronisers, gate state, timeout timer and registered commands
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_pipe <= '0;
      s2_pipe <= '0;
      state   <= CLOSED;
      timer   <= '0;
      a       <= 1'b0;
      c       <= 1'b1;
      alarm   <= 1'b0;
    end else begin
      s1_pipe <= {s1_pipe[1:0], s1};
      s2_pipe <= {s2_pipe[1:0], s2};
      // Something crossed a shut door: tailgating
      alarm   <= s2_edge & (state == CLOSED);
      case (state)
        CLOSED: begin
          if (req_edge && grant) begin
            state <= OPEN;
            timer <= TW'(TOPEN - 1);
            a     <= 1'b1;
            c     <= 1'b0;
          end
        end
        OPEN: begin
          // A passage in the last timer cycle still counts
          if (s2_edge) begin
            state <= PASS;
          end else if (timer == '0) begin
            state <= CLOSED;
            a     <= 1'b0;
            c     <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PASS: begin
          if (!s2_pipe[1]) begin
            state <= CLOSED;
            a     <= 1'b0;
            c     <= 1'b1;
          end
        end
        default: begin
          state <= CLOSED;
          a     <= 1'b0;
          c     <= 1'b1;
        end
      endcase
    end
  end

endmodule : gate_fsm
`default_nettype wire

// File: rtl/almacen_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : almacen_gate_ctrl
// Description : Multi-gate warehouse access controller. NCH gates, each an
//               entry or exit gate, share one occupancy counter bounded by
//               CAP. Gates reserve a slot before opening; lower-index gates
//               win when slots run out.
// Revision    : 1.0 - initial release
// ============================================================================
module almacen_gate_ctrl
  import almacen_pkg::*;
#(
  parameter int             NCH   = 2,
  parameter int             CAP   = 15,
  parameter int             CW    = 4,
  parameter int             TOPEN = 8,
  parameter logic [NCH-1:0] DIR   = NCH'(2'b01)
) (
  input  logic                clk,
  input  logic                rst,
  almacen_gate_ctrl_if.slave  bus
);

  // Wide enough for count plus up to 8 pending/granted gates
  localparam int AW = CW + 4;

  logic [NCH-1:0] req_edge;
  logic [NCH-1:0] pass_edge;
  logic [NCH-1:0] is_open;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] gate_a;
  logic [NCH-1:0] gate_c;
  logic [NCH-1:0] gate_alarm;

  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  logic [AW-1:0]  pend_in;
  logic [AW-1:0]  pend_out;
  logic [AW-1:0]  cum_in;
  logic [AW-1:0]  cum_out;
  logic [AW-1:0]  n_inc;
  logic [AW-1:0]  n_dec;
  logic [AW-1:0]  sum_up;
  logic [AW-1:0]  sum_net;
  logic [CW-1:0]  count_next;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_gate
      gate_fsm #(
        .TOPEN (TOPEN)
      ) u_gate (
        .clk       (clk),
        .rst       (rst),
        .s1        (bus.s1[gi]),
        .s2        (bus.s2[gi]),
        .grant     (grant[gi]),
        .req_edge  (req_edge[gi]),
        .pass_edge (pass_edge[gi]),
        .is_open   (is_open[gi]),
        .a         (gate_a[gi]),
        .c         (gate_c[gi]),
        .alarm     (gate_alarm[gi])
      );
    end
  endgenerate

  // Outstanding reservations: gates that are open but not yet crossed
  always_comb begin
    pend_in  = '0;
    pend_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (is_open[i]) begin
        if (DIR[i] == ENTRY) pend_in  = pend_in  + AW'(1);
        else                 pend_out = pend_out + AW'(1);
      end
    end
  end

  // Priority chain: each grant consumes a slot seen by higher-index gates
  always_comb begin
    grant   = '0;
    cum_in  = '0;
    cum_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (req_edge[i]) begin
        if (DIR[i] == ENTRY) begin
          if ((AW'(count) + pend_in + cum_in) < AW'(CAP)) begin
            grant[i] = 1'b1;
            cum_in   = cum_in + AW'(1);
          end
        end else begin
          if (AW'(count) > (pend_out + cum_out)) begin
            grant[i] = 1'b1;
            cum_out  = cum_out + AW'(1);
          end
        end
      end
    end
  end

  // Net occupancy change of all passages this cycle, saturated at 0/CAP
  always_comb begin
    n_inc = '0;
    n_dec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pass_edge[i]) begin
        if (DIR[i] == ENTRY) n_inc = n_inc + AW'(1);
        else                 n_dec = n_dec + AW'(1);
      end
    end
    sum_up = AW'(count) + n_inc;
    if (sum_up < n_dec) sum_net = '0;
    else                sum_net = sum_up - n_dec;
    if (sum_net > AW'(CAP)) count_next = CW'(CAP);
    else                    count_next = sum_net[CW-1:0];
  end

  // Occupancy counter with flags registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(CAP));
      empty <= (count_next == '0);
    end
  end

  assign bus.a     = gate_a;
  assign bus.c     = gate_c;
  assign bus.alarm = gate_alarm;
  assign bus.count = count;
  assign bus.full  = full;
  assign bus.empty = empty;

endmodule : almacen_gate_ctrl
`default_nettype wire

// File: doc/almacen_gate_ctrl.md
# almacen_gate_ctrl

Parametrised multi-gate warehouse access controller. It is the successor of the single-door two-sensor FSM. It drives NCH independent gates, each configured as an entry or exit gate, and keeps a shared occupancy counter bounded by CAP. Gates reserve a slot before opening and close automatically on timeout. Tailgating through a closed gate raises an alarm. It sits between the raw gate sensors and the door actuators.

## Interface
- NCH, 2, number of gates (1..8)
- CAP, 15, warehouse capacity in items (≥1)
- CW, 4, counter width; must satisfy 2^CW > CAP
- TOPEN, 8, cycles a gate stays open waiting for passage (≥2)
- DIR, 2'b01, per-gate mode mask: bit i=1 entry gate (increments), 0 exit gate (decrements)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  **reset is synchronous and active-high**
- s1  in  NCH  request sensor per gate (item waiting at gate)
- s2  in  NCH  passage sensor per gate (item crossing gate)
- a  out  NCH  open command per gate, registered
- c  out  NCH  close command per gate, registered, always ~a
- count  out  CW  current occupancy
- full  out  1  count == CAP
- empty  out  1  count == 0
- alarm  out  NCH  one-cycle pulse: s2 rising edge on a CLOSED gate

## Operation
- Inputs pass through 2-flop synchroniser; edge = q1 & ~q2 (rising edge only).
- Per-gate FSM states: CLOSED (a=0,c=1), OPEN (a=1,c=0), PASS (a=1,c=0).
- CLOSED→OPEN: s1 edge and grant; timer loads TOPEN-1.
- OPEN→PASS: s2 edge; count ±1 (entry +1, exit −1) on the same edge.
- OPEN→CLOSED: timer==0 with no s2 edge; count unchanged, reservation released.
- PASS→CLOSED: synchronised s2 low.
- s1 edges in OPEN/PASS are ignored. s2 edge in CLOSED is ignored for counting and pulses alarm[i].
- Reservation: pend_in = entry gates in OPEN; pend_out = exit gates in OPEN.
- Entry gate i granted iff count + pend_in + (entry grants to lower-index gates this cycle) < CAP.
- Exit gate i granted iff count − pend_out − (lower-index exit grants) > 0.
- Lowest index wins when slots run out. A denied request is dropped; a new s1 edge is needed to retry.
- Counter update is the sum of all gates' ±1 in one cycle. Reservation guarantees 0 ≤ count ≤ CAP. Counter saturates defensively at 0/CAP.
- full/empty are registered, consistent with count.

## Timing
- Reset values: a=0, c=all 1s, count=0, empty=1, full=0, alarm=0, all FSMs CLOSED, timers 0, synchronisers 0.
- Reset asserted mid-operation: all of the above apply at the next edge. Pending reservations are discarded. No count is applied on that edge.
- s1 high sampled at edge k → edge visible after k+1 → a=1 after edge k+2.
- s2 high sampled at edge k → count and state PASS updated after edge k+2.
- Timeout: a=1 for exactly TOPEN cycles if no passage.
- s2 edge and timer==0 in the same cycle: passage wins (PASS, count updated).
- Simultaneous entry and exit passages net out. With one +1 and one −1, count is unchanged and full/empty are re-evaluated.

## Structure
- Package almacen_pkg: state encoding (CLOSED, OPEN, PASS), gate mode constants ENTRY=1/EXIT=0.
- Sub-module gate_fsm: one per gate. Contains synchroniser, edge detect, timer, and state. Takes grant in, gives req_edge/pass_edge/is_open out.
- Top level holds grant arbitration (priority chain), pending counts, occupancy counter, and flags.

## Test plan
- Reset, then idle: a=0, c=2'b11, count=0, empty=1, full=0 held for 20 cycles.
- Gate0 (entry): s1 pulse, s2 high 3 cycles later → a[0]=1 two cycles after s1; count 0→1; PASS; gate closes after s2 falls.
- Gate0: s1 pulse, no s2 → a[0] high exactly TOPEN cycles, then closes; count stays 0.
- CAP=1, count=0, entry gates 0 and 1 request on the same cycle → only a[0] opens. Count reaches 1, full=1. Gate1 re-request is denied.
- Exit gate with empty=1 requests → stays closed. s2 pulse on the closed gate → alarm one cycle, count unchanged.
- Entry gate 0 and exit gate 1 pass on the same cycle at count=5 → count stays 5. Reset mid-OPEN → everything back to reset values next cycle.
